// File: rtl/mult_rr_pkg.sv
// Shared types and helpers for the round-robin multiplier scheduler.
package mult_rr_pkg;

    // BLANK while the post-reset flush counter is non-zero, RUN afterwards.
    typedef enum logic {
        BLANK = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Bits needed to hold a requester index.
    function automatic int id_width(input int num_req);
        return (num_req < 2) ? 1 : $clog2(num_req);
    endfunction

    // Multiplier latency from start sample to done/P.
    function automatic int latency(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/mult_rr_scheduler_rr_arbiter.sv
// Combinational round-robin pick: searches from ptr+1 upward (mod NUM_REQ)
// and returns the first requester found as a one-hot grant plus its index.
// The pointer register lives in the parent.
module rr_arbiter
    import mult_rr_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDW = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDW-1:0]     idx_o,
    output logic               valid_o
);

    logic found;
    int   j;

    // Rotating priority scan starting just after the last winner.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = (int'(ptr_i) + k) % NUM_REQ;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IDW'(j);
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/mult_rr_scheduler.sv
// Shares one fixed-latency pipelined multiplier among NUM_REQ requesters.
// Round-robin issue, in-order tag FIFO routes each product back to its owner.
// After any reset the block blanks for LATENCY cycles so stale results from
// the unreset multiplier pipeline are never routed.
// Optional perf counters: define MULT_RR_SCHEDULER_PERF_EN.
module mult_rr_scheduler
    import mult_rr_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_x,
    input  logic [NUM_REQ*WIDTH-1:0] req_y,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]         mul_x,
    output logic [WIDTH-1:0]         mul_y,
    output logic                     mul_start,
    input  logic [2*WIDTH-1:0]       mul_p,
    input  logic                     mul_done,
    output logic [NUM_REQ-1:0]       resp_valid,
    output logic [2*WIDTH-1:0]       resp_p,
    output logic                     err
`ifdef MULT_RR_SCHEDULER_PERF_EN
    ,
    output logic [31:0]              perf_grants,
    output logic [31:0]              perf_stalls
`endif
);

    localparam int LATENCY = latency(WIDTH);
    localparam int IDW     = id_width(NUM_REQ);
    localparam int CW      = $clog2(LATENCY + 1);
    localparam int AW      = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [CW-1:0]  blank_q, blank_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic           err_q, err_d;
    logic [IDW-1:0] tag_mem [LATENCY];

    state_t               state;
    logic                 act, grant, do_push, do_pop, full, empty;
    logic [NUM_REQ-1:0]   arb_gnt;
    logic [IDW-1:0]       arb_idx;
    logic                 arb_valid;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Everything visible is gated by reset_n so reset cycles are quiet.
    assign state   = (blank_q == '0) ? RUN : BLANK;
    assign act     = reset_n && (state == RUN);
    assign grant   = act && arb_valid;
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(LATENCY));
    assign do_pop  = act && mul_done && !empty;
    assign do_push = grant && (!full || do_pop);

    // Next-state for pointer, flush counter, FIFO pointers and error flag.
    always_comb begin
        blank_d = (blank_q == '0) ? blank_q : blank_q - 1'b1;
        ptr_d   = grant ? arb_idx : ptr_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (do_push) wr_d = (wr_q == AW'(LATENCY - 1)) ? '0 : wr_q + 1'b1;
        if (do_pop)  rd_d = (rd_q == AW'(LATENCY - 1)) ? '0 : rd_q + 1'b1;
        if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
        else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
        // Done with nothing outstanding, or a push into a full FIFO.
        err_d = err_q || (act && mul_done && empty) || (grant && full && !do_pop);
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            blank_q <= CW'(LATENCY);
            ptr_q   <= IDW'(NUM_REQ - 1);
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            blank_q <= blank_d;
            ptr_q   <= ptr_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Tag storage; contents are don't-care until pushed.
    always_ff @(posedge clock) begin
        if (do_push) tag_mem[wr_q] <= arb_idx;
    end

    // Issue mux and response routing, both same-cycle combinational.
    always_comb begin
        req_ready  = grant ? arb_gnt : '0;
        mul_start  = grant;
        mul_x      = '0;
        mul_y      = '0;
        resp_valid = '0;
        resp_p     = '0;
        if (grant) begin
            mul_x = req_x[int'(arb_idx)*WIDTH +: WIDTH];
            mul_y = req_y[int'(arb_idx)*WIDTH +: WIDTH];
        end
        if (do_pop) begin
            resp_valid[tag_mem[rd_q]] = 1'b1;
            resp_p                    = mul_p;
        end
    end

    assign err = err_q;

`ifdef MULT_RR_SCHEDULER_PERF_EN
    logic [31:0] grants_q, stalls_q;

    // Grant count and cycles where at least one requester was left waiting.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            grants_q <= '0;
            stalls_q <= '0;
        end else begin
            if (grant) grants_q <= grants_q + 32'd1;
            if (state == RUN && $countones(req_valid) >= 2) stalls_q <= stalls_q + 32'd1;
        end
    end

    assign perf_grants = grants_q;
    assign perf_stalls = stalls_q;
`endif

endmodule
